// File: rtl/ahb_mem_slave.sv
// AHB-Lite word memory responder with programmable OKAY wait states and a
// two-cycle ERROR response for bad size, misalignment or out-of-range addresses.
module ahb_mem_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hready_out,
    output logic        hresp,
    output logic [2:0]  dbg_state_o
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [1:0]    size_q, size_d;

    logic [31:0]   mem_q [MEM_DEPTH];

    logic          take;
    logic          addr_err;
    logic          commit;
    logic [3:0]    lanes;
    logic [AW-1:0] idx;

    // Handshake: an address phase is taken when hsel & htrans[1] & hready are
    // high at a rising edge; its data phase ends on the cycle hready_out is high.
    assign take = hsel & htrans[1] & hready &
                  ((state_q == ST_IDLE) | (state_q == ST_DATA) | (state_q == ST_ERR2));

    assign addr_err = hsize[2] | (hsize[1] & hsize[0])
                    | ((hsize == 3'b001) & haddr[0])
                    | ((hsize == 3'b010) & (haddr[1:0] != 2'b00))
                    | (|haddr[31:AW+2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        if (take) begin
            addr_d  = haddr[AW+1:0];
            write_d = hwrite;
            size_d  = hsize[1:0];
        end
        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_DATA;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: begin
                if (!take) begin
                    state_d = ST_IDLE;
                end else if (addr_err) begin
                    state_d = ST_ERR1;
                end else if (WAIT_STATES == 0) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'(WAIT_STATES);
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Little-endian lane enables from the registered address and size.
    always_comb begin
        case (size_q)
            2'b00:   lanes = 4'b0001 << addr_q[1:0];
            2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    assign idx    = addr_q[AW+1:2];
    assign commit = (state_q == ST_DATA) & write_q;

    // Memory is deliberately not reset.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes[b]) mem_q[idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata      = ((state_q == ST_DATA) & ~write_q) ? mem_q[idx] : 32'h0;
    assign hready_out  = (state_q != ST_WAIT) & (state_q != ST_ERR1);
    assign hresp       = (state_q == ST_ERR1) | (state_q == ST_ERR2);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one instance with two wait states, one
// with none, sharing the bus inputs and selected by use_b.
module tb_ahb_mem_slave;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic        use_b;
    logic        stall;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;

    logic [31:0] hrdata_a, hrdata_b;
    logic        ho_a, ho_b, hresp_a, hresp_b;
    logic [2:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    assign hready = ~stall & (use_b ? ho_b : ho_a);

    ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(2)) dut_a (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel & ~use_b), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata_a), .hready_out(ho_a), .hresp(hresp_a),
        .dbg_state_o(st_a)
    );

    ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel & use_b), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata_b), .hready_out(ho_b), .hresp(hresp_b),
        .dbg_state_o(st_b)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [1:0] trans, input logic wr,
                              input logic [2:0] size, input logic [31:0] addr);
        hsel   = 1'b1;
        htrans = trans;
        hwrite = wr;
        hsize  = size;
        haddr  = addr;
    endtask

    task automatic idle_bus();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'b010;
        haddr  = 32'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        hresetn = 1'b0;
        step();
        step();
        checks++; if (ho_a !== 1'b1) begin errors++; $display("FAIL rst_ready_a got=%b exp=1", ho_a); end
        checks++; if (hresp_a !== 1'b0) begin errors++; $display("FAIL rst_resp_a got=%b exp=0", hresp_a); end
        checks++; if (hrdata_a !== 32'h0) begin errors++; $display("FAIL rst_rdata_a got=%h exp=0", hrdata_a); end
        checks++; if (st_b !== S_IDLE) begin errors++; $display("FAIL rst_state_b got=%0d exp=%0d", st_b, S_IDLE); end
        hresetn = 1'b1;
        step();
        // Reset in the middle of a wait-stated write
        addr_phase(2'b10, 1'b1, 3'b010, 32'h30);
        step();
        idle_bus();
        hwdata = 32'hCAFE_F00D;
        checks++; if (st_a !== S_WAIT) begin errors++; $display("FAIL midwait_state got=%0d exp=%0d", st_a, S_WAIT); end
        checks++; if (ho_a !== 1'b0) begin errors++; $display("FAIL midwait_ready got=%b exp=0", ho_a); end
        hresetn = 1'b0;
        #1;
        checks++; if (ho_a !== 1'b1) begin errors++; $display("FAIL async_rst_ready got=%b exp=1", ho_a); end
        checks++; if (hresp_a !== 1'b0) begin errors++; $display("FAIL async_rst_resp got=%b exp=0", hresp_a); end
        checks++; if (st_a !== S_IDLE) begin errors++; $display("FAIL async_rst_state got=%0d exp=%0d", st_a, S_IDLE); end
        step();
        checks++; if (hrdata_a !== 32'h0) begin errors++; $display("FAIL async_rst_rdata got=%h exp=0", hrdata_a); end
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_idle_busy();
        addr_phase(2'b00, 1'b1, 3'b010, 32'h10);
        step();
        checks++; if (ho_a !== 1'b1 || hresp_a !== 1'b0) begin errors++; $display("FAIL idle_okay got=%b/%b exp=1/0", ho_a, hresp_a); end
        checks++; if (st_a !== S_IDLE) begin errors++; $display("FAIL idle_state got=%0d exp=%0d", st_a, S_IDLE); end
        addr_phase(2'b01, 1'b0, 3'b010, 32'h10);
        step();
        checks++; if (ho_a !== 1'b1 || hresp_a !== 1'b0) begin errors++; $display("FAIL busy_okay got=%b/%b exp=1/0", ho_a, hresp_a); end
        checks++; if (st_a !== S_IDLE) begin errors++; $display("FAIL busy_state got=%0d exp=%0d", st_a, S_IDLE); end
        idle_bus();
        step();
    endtask

    task automatic test_word_rw();
        logic [2:0] pat;
        pat = 3'b100;  // hready_out per data-phase cycle, first cycle in bit 0
        addr_phase(2'b10, 1'b1, 3'b010, 32'h10);
        step();
        idle_bus();
        hwdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            checks++; if (ho_a !== pat[c] || hresp_a !== 1'b0) begin errors++; $display("FAIL word_wr_phase cyc=%0d got=%b/%b exp=%b/0", c, ho_a, hresp_a, pat[c]); end
            step();
        end
        hwdata = 32'h0;
        addr_phase(2'b10, 1'b0, 3'b010, 32'h10);
        step();
        idle_bus();
        for (int c = 0; c < 3; c++) begin
            checks++; if (ho_a !== pat[c]) begin errors++; $display("FAIL word_rd_phase cyc=%0d got=%b exp=%b", c, ho_a, pat[c]); end
            if (c == 2) begin
                checks++; if (hrdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_rd_data got=%h exp=deadbeef", hrdata_a); end
            end else begin
                checks++; if (hrdata_a !== 32'h0) begin errors++; $display("FAIL word_rd_waitdata cyc=%0d got=%h exp=0", c, hrdata_a); end
            end
            step();
        end
        checks++; if (st_a !== S_IDLE) begin errors++; $display("FAIL word_end_state got=%0d exp=%0d", st_a, S_IDLE); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] addrs [3];
        logic [2:0]  sizes [3];
        logic [31:0] datas [3];
        addrs = '{32'h20, 32'h21, 32'h22};
        sizes = '{3'b010, 3'b000, 3'b001};
        datas = '{32'h1122_3344, 32'hFFFF_AAFF, 32'h5566_FFFF};
        for (int i = 0; i < 3; i++) begin
            addr_phase(2'b10, 1'b1, sizes[i], addrs[i]);
            step();
            idle_bus();
            hwdata = datas[i];
            step();
            step();
            checks++; if (st_a !== S_DATA) begin errors++; $display("FAIL lane_wr_data_state idx=%0d got=%0d exp=%0d", i, st_a, S_DATA); end
            step();
        end
        hwdata = 32'h0;
        addr_phase(2'b10, 1'b0, 3'b010, 32'h20);
        step();
        idle_bus();
        step();
        step();
        checks++; if (hrdata_a !== 32'h5566_AA44) begin errors++; $display("FAIL lane_rd_data got=%h exp=5566aa44", hrdata_a); end
        step();
    endtask

    task automatic test_errors();
        logic        wrs   [4];
        logic [2:0]  sizes [4];
        logic [31:0] addrs [4];
        wrs   = '{1'b0, 1'b0, 1'b0, 1'b1};
        sizes = '{3'b010, 3'b011, 3'b010, 3'b011};
        addrs = '{32'h02, 32'h00, 32'h400, 32'h10};
        for (int i = 0; i < 4; i++) begin
            addr_phase(2'b10, wrs[i], sizes[i], addrs[i]);
            step();
            idle_bus();
            hwdata = 32'h1234_5678;
            checks++; if (ho_a !== 1'b0 || hresp_a !== 1'b1) begin errors++; $display("FAIL err1 idx=%0d got=%b/%b exp=0/1", i, ho_a, hresp_a); end
            checks++; if (st_a !== S_ERR1) begin errors++; $display("FAIL err1_state idx=%0d got=%0d exp=%0d", i, st_a, S_ERR1); end
            step();
            checks++; if (ho_a !== 1'b1 || hresp_a !== 1'b1) begin errors++; $display("FAIL err2 idx=%0d got=%b/%b exp=1/1", i, ho_a, hresp_a); end
            step();
            checks++; if (ho_a !== 1'b1 || hresp_a !== 1'b0) begin errors++; $display("FAIL err_end idx=%0d got=%b/%b exp=1/0", i, ho_a, hresp_a); end
        end
        hwdata = 32'h0;
        addr_phase(2'b10, 1'b0, 3'b010, 32'h10);
        step();
        idle_bus();
        step();
        step();
        checks++; if (hrdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL err_wr_unchanged got=%h exp=deadbeef", hrdata_a); end
        step();
    endtask

    task automatic test_back_to_back();
        use_b = 1'b1;
        addr_phase(2'b10, 1'b1, 3'b010, 32'h40);
        step();
        checks++; if (ho_b !== 1'b1 || st_b !== S_DATA) begin errors++; $display("FAIL b2b_wr ready/state got=%b/%0d exp=1/%0d", ho_b, st_b, S_DATA); end
        addr_phase(2'b10, 1'b0, 3'b010, 32'h40);
        hwdata = 32'h0123_4567;
        step();
        idle_bus();
        hwdata = 32'h0;
        checks++; if (ho_b !== 1'b1 || st_b !== S_DATA) begin errors++; $display("FAIL b2b_rd ready/state got=%b/%0d exp=1/%0d", ho_b, st_b, S_DATA); end
        checks++; if (hrdata_b !== 32'h0123_4567) begin errors++; $display("FAIL b2b_rd_data got=%h exp=01234567", hrdata_b); end
        step();
        checks++; if (ho_b !== 1'b1 || st_b !== S_IDLE) begin errors++; $display("FAIL b2b_end got=%b/%0d exp=1/%0d", ho_b, st_b, S_IDLE); end
        use_b = 1'b0;
    endtask

    task automatic test_bus_stall();
        stall = 1'b1;
        addr_phase(2'b10, 1'b1, 3'b010, 32'h50);
        step();
        checks++; if (st_a !== S_IDLE) begin errors++; $display("FAIL stall_state1 got=%0d exp=%0d", st_a, S_IDLE); end
        addr_phase(2'b11, 1'b0, 3'b010, 32'h54);
        step();
        checks++; if (st_a !== S_IDLE || ho_a !== 1'b1) begin errors++; $display("FAIL stall_state2 got=%0d/%b exp=%0d/1", st_a, ho_a, S_IDLE); end
        idle_bus();
        stall = 1'b0;
        step();
    endtask

    initial begin
        use_b  = 1'b0;
        stall  = 1'b0;
        hwdata = 32'h0;
        idle_bus();
        test_reset();
        test_idle_busy();
        test_word_rw();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_bus_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
